adc_stream_packer: RTL and testbench

- Sits directly upstream of one Xillybus 32-bit read channel (user_r_chN_read_*) in the AD9284 capture design.
- Accepts 8-bit ADC samples, already synchronous to bus_clk, and packs four samples into each 32-bit word.
- Buffers packed words in an internal FIFO and presents them on the Xillybus read-FIFO interface (rden/data/empty/eof/open).
- Capture is armed by the host opening the device file and lasts for a programmed word count. The block then signals end-of-file.

---
 rtl/adc_stream_packer.sv | 164 ++++++++++++++++
 tb/tb_adc_stream_packer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_stream_packer.sv
// Packs 8-bit ADC samples four to a 32-bit word and serves them on a Xillybus read-FIFO port.
// Latency: packed word visible (empty low) one cycle after its 4th sample; read data one cycle after rden.
// Backpressure: none toward the ADC; a word arriving at a full FIFO is dropped and sets sticky overflow.
//
// Ports: bus_clk/reset (sync, active-high); adc_valid/adc_data sample strobe and value;
//        capture_len words per capture (0 = continuous); user_r_read_* Xillybus read side;
//        overflow sticky drop flag; capturing high while packing.
module adc_stream_packer #(
  parameter int FIFO_AW  = 9,
  parameter int SAMPLE_W = 8
) (
  input  logic                bus_clk,
  input  logic                reset,
  input  logic                adc_valid,
  input  logic [SAMPLE_W-1:0] adc_data,
  input  logic [15:0]         capture_len,
  input  logic                user_r_read_open,
  input  logic                user_r_read_rden,
  output logic [31:0]         user_r_read_data,
  output logic                user_r_read_empty,
  output logic                user_r_read_eof,
  output logic                overflow,
  output logic                capturing
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int PW    = FIFO_AW + 1;

  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN, DONE} state_t;

  state_t                state_q, state_d;
  logic [15:0]           len_q, len_d;
  logic [15:0]           word_cnt_q, word_cnt_d;
  logic [1:0]            pack_cnt_q, pack_cnt_d;
  logic [3*SAMPLE_W-1:0] pack_q, pack_d;   // first three samples of the word being built
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [31:0]           data_q, data_d;
  logic                  empty_q, empty_d, eof_q, eof_d;
  logic                  overflow_q, overflow_d, capturing_q, capturing_d;

  logic [31:0]           mem [DEPTH];
  logic [PW-1:0]         occ_cur, occ_nxt;
  logic                  rd_accept, push, full;
  logic [31:0]           word;

  assign occ_cur = wr_ptr_q - rd_ptr_q;
  assign full    = (occ_cur == PW'(DEPTH));
  assign word    = {adc_data, pack_q};
  // empty_q is forced high outside CAPTURE/DRAIN, so it alone gates reads.
  assign rd_accept = user_r_read_rden && user_r_read_open && !empty_q;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    word_cnt_d  = word_cnt_q;
    pack_cnt_d  = pack_cnt_q;
    pack_d      = pack_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    data_d      = data_q;
    overflow_d  = overflow_q;
    push        = 1'b0;

    if (rd_accept) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      data_d   = mem[rd_ptr_q[FIFO_AW-1:0]];
    end

    unique case (state_q)
      IDLE: begin
        if (user_r_read_open) begin
          state_d    = CAPTURE;
          len_d      = capture_len;
          overflow_d = 1'b0;
          pack_cnt_d = 2'd0;
          word_cnt_d = 16'd0;
        end
      end
      CAPTURE: begin
        if (adc_valid) begin
          pack_cnt_d = pack_cnt_q + 2'd1;
          case (pack_cnt_q)
            2'd0:    pack_d[SAMPLE_W-1:0]            = adc_data;
            2'd1:    pack_d[2*SAMPLE_W-1:SAMPLE_W]   = adc_data;
            2'd2:    pack_d[3*SAMPLE_W-1:2*SAMPLE_W] = adc_data;
            default: ;
          endcase
          if (pack_cnt_q == 2'd3) begin
            if (word_cnt_q != 16'hFFFF) word_cnt_d = word_cnt_q + 16'd1;
            // A simultaneous read frees the slot this push needs.
            if (!full || rd_accept) begin
              push = 1'b1;
            end else begin
              overflow_d = 1'b1;
              if (len_q != 16'd0) state_d = DRAIN;
            end
            if (len_q != 16'd0 && (word_cnt_q + 16'd1) == len_q) state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // occ_cur == 0 implies empty_q, so no read can be in flight.
        if (occ_cur == '0) state_d = DONE;
      end
      DONE: ;
    endcase

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);

    // Host closed the file: abandon everything except the overflow record.
    if (state_q != IDLE && !user_r_read_open) begin
      state_d    = IDLE;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      pack_cnt_d = 2'd0;
      push       = 1'b0;
    end

    occ_nxt     = wr_ptr_d - rd_ptr_d;
    empty_d     = (state_d == CAPTURE || state_d == DRAIN) ? (occ_nxt == '0) : 1'b1;
    eof_d       = (state_d == DONE);
    capturing_d = (state_d == CAPTURE);
  end

  always_ff @(posedge bus_clk) begin
    if (reset) begin
      state_q     <= IDLE;
      len_q       <= '0;
      word_cnt_q  <= '0;
      pack_cnt_q  <= '0;
      pack_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      data_q      <= '0;
      empty_q     <= 1'b1;
      eof_q       <= 1'b0;
      overflow_q  <= 1'b0;
      capturing_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      word_cnt_q  <= word_cnt_d;
      pack_cnt_q  <= pack_cnt_d;
      pack_q      <= pack_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      data_q      <= data_d;
      empty_q     <= empty_d;
      eof_q       <= eof_d;
      overflow_q  <= overflow_d;
      capturing_q <= capturing_d;
    end
  end

  // Storage has no reset; the pointers define what is valid.
  always_ff @(posedge bus_clk) begin
    if (push) mem[wr_ptr_q[FIFO_AW-1:0]] <= word;
  end

  assign user_r_read_data  = data_q;
  assign user_r_read_empty = empty_q;
  assign user_r_read_eof   = eof_q;
  assign overflow          = overflow_q;
  assign capturing         = capturing_q;
endmodule

// File: tb/tb_adc_stream_packer.sv
module tb_adc_stream_packer;
  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;
  localparam int PH_IDLE = 0, PH_CAP = 1, PH_DRN = 2, PH_DONE = 3;

  logic        bus_clk = 1'b0;
  logic        reset = 1'b1;
  logic        adc_valid = 1'b0;
  logic [7:0]  adc_data = 8'h00;
  logic [15:0] capture_len = 16'd0;
  logic        user_r_read_open = 1'b0;
  logic        user_r_read_rden = 1'b0;
  logic [31:0] user_r_read_data;
  logic        user_r_read_empty, user_r_read_eof, overflow, capturing;

  int total = 0;
  int bad = 0;
  string tag = "init";

  adc_stream_packer #(.FIFO_AW(AW), .SAMPLE_W(8)) dut (
    .bus_clk(bus_clk), .reset(reset), .adc_valid(adc_valid), .adc_data(adc_data),
    .capture_len(capture_len), .user_r_read_open(user_r_read_open),
    .user_r_read_rden(user_r_read_rden), .user_r_read_data(user_r_read_data),
    .user_r_read_empty(user_r_read_empty), .user_r_read_eof(user_r_read_eof),
    .overflow(overflow), .capturing(capturing)
  );

  always #5 bus_clk = ~bus_clk;

  // Reference model: the host-visible word stream as a queue plus capture phase.
  int          m_ph = PH_IDLE;
  logic [31:0] m_q[$];
  logic [31:0] m_pack = '0;
  int          m_n = 0;
  int          m_words = 0;
  int          m_len = 0;
  bit          m_ovf = 1'b0;
  logic [31:0] m_data = '0;

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s/%s got=%b want=%b t=%0t", tag, nm, act, exp, $time);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s/%s got=%h want=%h t=%0t", tag, nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit o, input bit v, input logic [7:0] d, input bit r);
    int n0;
    bit rd;
    n0 = m_q.size();
    rd = r && o && (m_ph == PH_CAP || m_ph == PH_DRN) && n0 > 0;
    if (m_ph != PH_IDLE && !o) begin
      m_ph = PH_IDLE;
      m_q.delete();
      m_n = 0;
    end else if (m_ph == PH_IDLE) begin
      if (o) begin
        m_ph = PH_CAP; m_len = int'(capture_len); m_ovf = 1'b0; m_n = 0; m_words = 0;
      end
    end else if (m_ph != PH_DONE) begin
      if (rd) m_data = m_q.pop_front();
      if (m_ph == PH_DRN) begin
        if (n0 == 0) m_ph = PH_DONE;
      end else if (v) begin
        m_pack[8*m_n +: 8] = d;
        m_n++;
        if (m_n == 4) begin
          m_n = 0;
          m_words++;
          if (m_q.size() < DEPTH) m_q.push_back(m_pack);
          else begin
            m_ovf = 1'b1;
            if (m_len != 0) m_ph = PH_DRN;
          end
          if (m_len != 0 && m_words == m_len) m_ph = PH_DRN;
        end
      end
    end
  endtask

  task automatic check_model();
    bit e_empty;
    e_empty = (m_ph == PH_CAP || m_ph == PH_DRN) ? (m_q.size() == 0) : 1'b1;
    chk1("m_empty", user_r_read_empty, e_empty);
    chk1("m_eof", user_r_read_eof, m_ph == PH_DONE);
    chk1("m_cap", capturing, m_ph == PH_CAP);
    chk1("m_ovf", overflow, m_ovf);
    chk32("m_data", user_r_read_data, m_data);
  endtask

  task automatic step(input bit o, input bit v, input logic [7:0] d, input bit r);
    user_r_read_open = o; adc_valid = v; adc_data = d; user_r_read_rden = r;
    model_step(o, v, d, r);
    @(posedge bus_clk); #1;
    check_model();
  endtask

  task automatic do_reset(input bit o);
    reset = 1'b1; user_r_read_open = o; adc_valid = 1'b0; user_r_read_rden = 1'b0;
    @(posedge bus_clk); #1;
    reset = 1'b0;
    m_ph = PH_IDLE; m_q.delete(); m_ovf = 1'b0; m_data = '0; m_n = 0;
    check_model();
  endtask

  // Word built from samples with value equal to their index: word w = {4w+3,4w+2,4w+1,4w}.
  function automatic logic [31:0] idx_word(input int w);
    return {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)};
  endfunction

  typedef struct {
    bit o; bit v; logic [7:0] d; bit r;
    bit e_empty; bit e_eof; bit e_cap; bit e_ovf; logic [31:0] e_data;
  } vec_t;
  vec_t tbl[14];

  initial begin
    // Basic len=2 capture and drain, one row per cycle.
    tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0};
    tbl[1]  = '{1'b1, 1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0};
    tbl[2]  = '{1'b1, 1'b1, 8'h02, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0};
    tbl[3]  = '{1'b1, 1'b1, 8'h03, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0};
    tbl[4]  = '{1'b1, 1'b1, 8'h04, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
    tbl[5]  = '{1'b1, 1'b1, 8'h05, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
    tbl[6]  = '{1'b1, 1'b1, 8'h06, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
    tbl[7]  = '{1'b1, 1'b1, 8'h07, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
    tbl[8]  = '{1'b1, 1'b1, 8'h08, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[9]  = '{1'b1, 1'b1, 8'h09, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h04030201};
    tbl[10] = '{1'b1, 1'b1, 8'h0a, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h08070605};
    tbl[11] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h08070605};
    tbl[12] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h08070605};
    tbl[13] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h08070605};

    tag = "reset";
    do_reset(1'b0);
    chk1("rst_empty", user_r_read_empty, 1'b1);
    chk32("rst_data", user_r_read_data, 32'h0);

    tag = "table";
    capture_len = 16'd2;
    for (int i = 0; i < 14; i++) begin
      step(tbl[i].o, tbl[i].v, tbl[i].d, tbl[i].r);
      chk1("tv_empty", user_r_read_empty, tbl[i].e_empty);
      chk1("tv_eof", user_r_read_eof, tbl[i].e_eof);
      chk1("tv_cap", capturing, tbl[i].e_cap);
      chk1("tv_ovf", overflow, tbl[i].e_ovf);
      chk32("tv_data", user_r_read_data, tbl[i].e_data);
    end

    tag = "close_mid";
    do_reset(1'b0);
    capture_len = 16'd0;
    step(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 14; i++) step(1'b1, 1'b1, 8'(8'h10 + i), 1'b0);
    chk1("cm_cap", capturing, 1'b1);
    chk1("cm_empty_before", user_r_read_empty, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    chk1("cm_empty", user_r_read_empty, 1'b1);
    chk1("cm_eof", user_r_read_eof, 1'b0);
    chk1("cm_cap_off", capturing, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 8'(8'hA0 + i), 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b1);
    chk32("cm_word", user_r_read_data, 32'hA3A2A1A0);
    chk1("cm_one_word", user_r_read_empty, 1'b1);

    tag = "overflow_len";
    do_reset(1'b0);
    capture_len = 16'd10;
    step(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, 8'(i), 1'b0);
      if (i == 18) chk1("ol_cap_4th", capturing, 1'b1);
    end
    chk1("ol_cap_5th", capturing, 1'b0);
    chk1("ol_ovf", overflow, 1'b1);
    for (int j = 0; j < 4; j++) begin
      step(1'b1, 1'b0, 8'h00, 1'b1);
      chk32("ol_word", user_r_read_data, idx_word(j));
    end
    step(1'b1, 1'b0, 8'h00, 1'b0);
    chk1("ol_eof", user_r_read_eof, 1'b1);
    chk1("ol_eof_empty", user_r_read_empty, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    chk1("ol_ovf_kept", overflow, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    chk1("ol_ovf_rearm", overflow, 1'b0);

    tag = "rden_empty";
    do_reset(1'b0);
    capture_len = 16'd0;
    step(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 8'h00, 1'b1);
      chk32("re_data_hold", user_r_read_data, 32'h0);
    end
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 8'(8'hC0 + i), 1'b1);
    chk1("re_push_visible", user_r_read_empty, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b1);
    chk32("re_word", user_r_read_data, 32'hC3C2C1C0);
    chk1("re_empty_after", user_r_read_empty, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b1);
    chk32("re_word_hold", user_r_read_data, 32'hC3C2C1C0);

    tag = "full_rw";
    do_reset(1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    for (int w = 0; w < 6; w++) begin
      for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 8'(4*w+k), 1'b0);
      step(1'b1, 1'b0, 8'h00, 1'b1);
      chk32("fr_pre", user_r_read_data, idx_word(w));
    end
    for (int s = 24; s < 43; s++) step(1'b1, 1'b1, 8'(s), 1'b0);
    step(1'b1, 1'b1, 8'(43), 1'b1);
    chk32("fr_same_cycle", user_r_read_data, idx_word(6));
    chk1("fr_ovf", overflow, 1'b0);
    for (int w = 7; w < 11; w++) begin
      step(1'b1, 1'b0, 8'h00, 1'b1);
      chk32("fr_order", user_r_read_data, idx_word(w));
    end
    chk1("fr_empty", user_r_read_empty, 1'b1);

    tag = "reset_mid";
    do_reset(1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    for (int s = 0; s < 20; s++) step(1'b1, 1'b1, 8'(s), 1'b0);
    chk1("rm_cont_cap", capturing, 1'b1);
    chk1("rm_cont_ovf", overflow, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b1);
    chk32("rm_data_pre", user_r_read_data, idx_word(1));
    do_reset(1'b1);
    chk1("rm_empty", user_r_read_empty, 1'b1);
    chk1("rm_eof", user_r_read_eof, 1'b0);
    chk1("rm_ovf", overflow, 1'b0);
    chk1("rm_cap", capturing, 1'b0);
    chk32("rm_data", user_r_read_data, 32'h0);

    tag = "random";
    for (int t = 0; t < 40; t++) begin
      int rp, vp, ncyc;
      bit o;
      capture_len = 16'($urandom_range(0, 9));
      rp = int'($urandom_range(0, 100));
      vp = int'($urandom_range(30, 100));
      ncyc = int'($urandom_range(40, 160));
      if ($urandom_range(0, 4) == 0) do_reset(1'($urandom_range(0, 1)));
      for (int c = 0; c < ncyc; c++) begin
        o = ($urandom_range(0, 99) >= 2);
        step(o, $urandom_range(0, 99) < vp, 8'($urandom), $urandom_range(0, 99) < rp);
      end
      step(1'b0, 1'b0, 8'h00, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
